block_buffer_ctrl: RTL and testbench

BLOCK_BUFFER_CTRL -- requirements
Module: block_buffer_ctrl

---
 rtl/block_buffer_ctrl.sv | 110 +++++++++++
 tb/tb_block_buffer_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_buffer_ctrl.sv
// block_buffer_ctrl: ping-pong bit buffer control between an input bit stream and a block encoder.
// The writer fills one bank while the read FSM streams the other, full bank to the encoder.
module block_buffer_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_length_flag,
    output logic        in_ready,
    output logic        wr_en,
    output logic        wr_bank,
    output logic [12:0] wr_addr,
    input  logic        enc_busy,
    input  logic        enc_done,
    output logic        enc_start,
    output logic        enc_length_flag,
    output logic        rd_en,
    output logic        rd_bank,
    output logic [12:0] rd_addr,
    output logic        rd_valid,
    output logic [1:0]  bank_full,
    output logic        err_done
);
    localparam logic [12:0] K_LONG_LAST  = 13'd6143;
    localparam logic [12:0] K_SHORT_LAST = 13'd1055;
    localparam logic [1:0]  RD_IDLE = 2'd0;
    localparam logic [1:0]  RD_READ = 2'd1;
    localparam logic [1:0]  RD_WAIT = 2'd2;

    logic [12:0] r_wr_cnt;
    logic [12:0] r_rd_cnt;
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [1:0]  r_bank_full;
    logic [1:0]  r_len;
    logic [1:0]  r_state;
    logic        r_enc_start;
    logic        r_enc_len;
    logic        r_rd_valid;
    logic        r_err_done;
    logic        w_wr_len;
    logic        w_wr_last;
    logic        w_rd_last;
    logic        w_start;
    logic        w_rd_done;
    logic [1:0]  w_set;
    logic [1:0]  w_clr;
    logic [1:0]  w_next;

    // The first beat of a block carries its own length flag before it is latched.
    always_comb begin
        in_ready  = !r_bank_full[r_wr_bank];
        wr_en     = in_valid & in_ready;
        w_wr_len  = (r_wr_cnt == 13'd0) ? in_length_flag : r_len[r_wr_bank];
        w_wr_last = wr_en & (r_wr_cnt == (w_wr_len ? K_LONG_LAST : K_SHORT_LAST));
        w_rd_last = (r_state == RD_READ) & (r_rd_cnt == (r_enc_len ? K_LONG_LAST : K_SHORT_LAST));
        w_start   = (r_state == RD_IDLE) & r_bank_full[r_rd_bank] & !enc_busy;
        w_rd_done = (r_state == RD_WAIT) & enc_done;
        w_set     = w_wr_last ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
        w_clr     = w_rd_done ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
        w_next    = w_start   ? RD_READ :
                    w_rd_last ? RD_WAIT :
                    w_rd_done ? RD_IDLE :
                    (r_state == 2'd3) ? RD_IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt    <= 13'd0;
            r_rd_cnt    <= 13'd0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_len       <= 2'b00;
            r_state     <= RD_IDLE;
            r_enc_start <= 1'b0;
            r_enc_len   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_err_done  <= 1'b0;
        end else begin
            if (wr_en)
                r_wr_cnt <= w_wr_last ? 13'd0 : r_wr_cnt + 13'd1;
            if (w_wr_last)
                r_wr_bank <= !r_wr_bank;
            if (wr_en && r_wr_cnt == 13'd0)
                r_len[r_wr_bank] <= in_length_flag;
            r_bank_full <= (r_bank_full | w_set) & ~w_clr;
            r_enc_start <= w_start;
            if (w_start)
                r_enc_len <= r_len[r_rd_bank];
            r_rd_cnt <= w_start ? 13'd0 : ((r_state == RD_READ && !w_rd_last) ? r_rd_cnt + 13'd1 : r_rd_cnt);
            r_rd_valid <= rd_en;
            if (enc_done && r_state != RD_WAIT)
                r_err_done <= 1'b1;
            if (w_rd_done)
                r_rd_bank <= !r_rd_bank;
            r_state <= w_next;
        end
    end

    assign wr_bank         = r_wr_bank;
    assign wr_addr         = r_wr_cnt;
    assign enc_start       = r_enc_start;
    assign enc_length_flag = r_enc_len;
    assign rd_en           = (r_state == RD_READ);
    assign rd_bank         = r_rd_bank;
    assign rd_addr         = r_rd_cnt;
    assign rd_valid        = r_rd_valid;
    assign bank_full       = r_bank_full;
    assign err_done        = r_err_done;
endmodule

// File: tb/tb_block_buffer_ctrl.sv
// tb_block_buffer_ctrl: directed scenarios; writes push expected read beats and length flags
// into queues that an independent monitor pops whenever the DUT reads or starts the encoder.
module tb_block_buffer_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_length_flag = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [12:0] wr_addr;
    logic        enc_busy = 1'b0;
    logic        enc_done = 1'b0;
    logic        enc_start;
    logic        enc_length_flag;
    logic        rd_en;
    logic        rd_bank;
    logic [12:0] rd_addr;
    logic        rd_valid;
    logic [1:0]  bank_full;
    logic        err_done;

    int n_vec = 0;
    int n_err = 0;
    int rd_q[$];
    bit len_q[$];
    int m_wcnt = 0;
    bit m_wbank = 1'b0;
    bit m_flag = 1'b0;
    int m_starts = 0;
    int n_start = 0;
    int rd_run = 0;

    block_buffer_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_length_flag(in_length_flag),
        .in_ready(in_ready), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .enc_busy(enc_busy), .enc_done(enc_done), .enc_start(enc_start),
        .enc_length_flag(enc_length_flag), .rd_en(rd_en), .rd_bank(rd_bank),
        .rd_addr(rd_addr), .rd_valid(rd_valid), .bank_full(bank_full), .err_done(err_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every encoder start and read beat is matched against the scoreboard.
    initial begin
        bit prev_rd_en = 1'b0;
        bit cur_f = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rd_en = 1'b0;
                rd_run = 0;
            end else begin
                if (enc_start) begin
                    if (len_q.size() == 0) check("enc_start_unexpected", 1, 0);
                    else check("enc_length_flag", enc_length_flag, len_q.pop_front());
                    cur_f = enc_length_flag;
                    rd_run = 0;
                    n_start++;
                end
                if (rd_en) begin
                    if (rd_q.size() == 0) check("rd_en_unexpected", 1, 0);
                    else check("rd_bank_addr", {rd_bank, rd_addr}, rd_q.pop_front());
                    check("len_hold", enc_length_flag, cur_f);
                    rd_run++;
                end
                check("rd_valid", rd_valid, prev_rd_en);
                prev_rd_en = rd_en;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        enc_done = 1'b0;
        next();
        next();
        reset = 1'b0;
        m_wcnt = 0;
        m_wbank = 1'b0;
        rd_q.delete();
        len_q.delete();
    endtask

    task automatic write_beats(input int n, input bit f, input bit done_last);
        int done_n = 0;
        int guard = 0;
        while (done_n < n && guard < 2 * n + 100) begin
            in_valid = 1'b1;
            in_length_flag = f;
            enc_done = done_last && (done_n == n - 1);
            @(negedge clk);
            if (wr_en) begin
                check("wr_addr", wr_addr, m_wcnt);
                check("wr_bank", wr_bank, m_wbank);
                if (m_wcnt == 0) m_flag = f;
                if (m_wcnt == (m_flag ? 6143 : 1055)) begin
                    for (int a = 0; a <= m_wcnt; a++) rd_q.push_back((int'(m_wbank) << 13) | a);
                    len_q.push_back(m_flag);
                    m_wcnt = 0;
                    m_wbank = !m_wbank;
                end else m_wcnt++;
                done_n++;
            end
            guard++;
            next();
        end
        in_valid = 1'b0;
        enc_done = 1'b0;
        if (done_n < n) check("write_timeout", done_n, n);
    endtask

    task automatic wait_reads(input int k);
        int g = 0;
        m_starts++;
        while (!(n_start == m_starts && rd_run > 0 && !rd_en) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20000) check("read_timeout", n_start, m_starts);
        else check("rd_count", rd_run, k);
        next();
    endtask

    task automatic pulse_done();
        enc_done = 1'b1;
        next();
        enc_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_en_follows", wr_en, 1);
        check("rst_bank_full", bank_full, 0);
        check("rst_enc_start", enc_start, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_enc_len", enc_length_flag, 0);
        check("rst_err_done", err_done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 0);
        in_valid = 1'b0;
        #1;
        check("rst_wr_en_low", wr_en, 0);
        do_reset();

        // enc_done in RD_IDLE only flags an error
        enc_done = 1'b1;
        next();
        enc_done = 1'b0;
        @(negedge clk);
        check("err_done_set", err_done, 1);
        check("err_bank_full", bank_full, 0);
        check("err_rd_bank", rd_bank, 0);
        check("err_rd_en", rd_en, 0);
        check("err_enc_start", enc_start, 0);
        check("err_in_ready", in_ready, 1);
        next();
        do_reset();
        @(negedge clk);
        check("err_done_cleared", err_done, 0);
        next();

        // single short block, encoder idle
        write_beats(1056, 1'b0, 1'b0);
        @(negedge clk);
        check("s1_bank_full", bank_full, 2'b01);
        check("s1_no_start_yet", enc_start, 0);
        check("s1_wr_bank", wr_bank, 1);
        next();
        @(negedge clk);
        check("s1_enc_start", enc_start, 1);
        next();
        wait_reads(1056);
        pulse_done();
        @(negedge clk);
        check("s1_bank_full_clr", bank_full, 0);
        check("s1_rd_bank", rd_bank, 1);
        check("s1_err_done", err_done, 0);
        next();

        // two long blocks, first held without enc_done
        do_reset();
        write_beats(6144, 1'b1, 1'b0);
        wait_reads(6144);
        write_beats(6144, 1'b1, 1'b0);
        @(negedge clk);
        check("s2_bank_full", bank_full, 2'b11);
        check("s2_in_ready", in_ready, 0);
        next();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s2_frozen_wr_en", wr_en, 0);
            check("s2_frozen_wr_addr", wr_addr, 0);
            next();
        end
        in_valid = 1'b0;
        pulse_done();
        @(negedge clk);
        check("s2_bank_full_after", bank_full, 2'b10);
        check("s2_rd_bank", rd_bank, 1);
        next();
        @(negedge clk);
        check("s2_enc_start", enc_start, 1);
        next();
        wait_reads(6144);
        pulse_done();
        @(negedge clk);
        check("s2_bank_full_end", bank_full, 0);
        next();

        // enc_done on the same edge as bank 1's final write
        do_reset();
        write_beats(1056, 1'b0, 1'b0);
        wait_reads(1056);
        write_beats(1056, 1'b0, 1'b1);
        @(negedge clk);
        check("s3_bank_full_swap", bank_full, 2'b10);
        check("s3_rd_bank", rd_bank, 1);
        check("s3_wr_bank", wr_bank, 0);
        next();
        wait_reads(1056);
        pulse_done();
        @(negedge clk);
        check("s3_bank_full_end", bank_full, 0);
        check("s3_err_done", err_done, 0);
        next();

        // reset mid-block
        do_reset();
        write_beats(500, 1'b0, 1'b0);
        @(negedge clk);
        check("s4_wr_addr_mid", wr_addr, 500);
        next();
        do_reset();
        @(negedge clk);
        check("s4_bank_full", bank_full, 0);
        check("s4_wr_addr", wr_addr, 0);
        next();
        write_beats(1, 1'b0, 1'b0);

        // mixed lengths with a busy encoder delaying the first start
        do_reset();
        enc_busy = 1'b1;
        write_beats(1056, 1'b0, 1'b0);
        @(negedge clk);
        check("s5_bank_full", bank_full, 2'b01);
        check("s5_busy_no_start", enc_start, 0);
        next();
        @(negedge clk);
        check("s5_busy_no_start2", enc_start, 0);
        check("s5_busy_no_rd", rd_en, 0);
        next();
        enc_busy = 1'b0;
        write_beats(6144, 1'b1, 1'b0);
        wait_reads(1056);
        pulse_done();
        wait_reads(6144);
        pulse_done();
        @(negedge clk);
        check("s5_bank_full_end", bank_full, 0);
        check("s5_rd_q_empty", rd_q.size(), 0);
        check("s5_len_q_empty", len_q.size(), 0);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
